// File: rtl/fpu_issue_sched.sv
// FPU issue/writeback scheduler: in-order accept, ops issue 1 cycle after accept, wb strobe L cycles after accept.
// Backpressure: req_ready drops on RAW/WAW hazards, writeback-slot collision, flush or reset.
module fpu_issue_sched #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_INV  = 4,
  parameter int LAT_SQRT = 4,
  parameter int LAT_MISC = 1,
  parameter int MAX_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_ctrl,
  input  logic [5:0]  req_ds,
  input  logic [5:0]  req_dt,
  input  logic [5:0]  req_dd,
  input  logic        flush,
  output logic        issue_valid,
  output logic [3:0]  issue_ctrl,
  output logic [5:0]  issue_dd,
  output logic        wb_valid,
  output logic [5:0]  wb_addr,
  output logic        busy,
  output logic [15:0] perf_stall
);

  logic [MAX_LAT:1] sr_v;
  logic [5:0]       sr_addr [1:MAX_LAT];
  logic [63:0]      pend;

  logic is_op, use_ds, use_dt;
  logic ds_haz, dt_haz, dd_haz, slot_busy, accept;
  int   req_lat;

  assign wb_valid = sr_v[1];
  assign wb_addr  = sr_addr[1];
  assign busy     = |sr_v;

  always_comb begin
    is_op  = (req_ctrl != 4'd0) && (req_ctrl != 4'd15);
    use_ds = is_op && (req_ctrl != 4'd14);
    use_dt = (req_ctrl == 4'd1) || (req_ctrl == 4'd2) || (req_ctrl == 4'd3) ||
             (req_ctrl == 4'd6) || (req_ctrl == 4'd7) || (req_ctrl == 4'd8);
    case (req_ctrl)
      4'd1, 4'd2: req_lat = LAT_ADD;
      4'd3:       req_lat = LAT_MUL;
      4'd4:       req_lat = LAT_INV;
      4'd5:       req_lat = LAT_SQRT;
      default:    req_lat = LAT_MISC;
    endcase
    // A register whose producer writes back this very cycle is already safe to read.
    ds_haz = use_ds && (req_ds != 6'd0) && pend[req_ds] && !(wb_valid && (wb_addr == req_ds));
    dt_haz = use_dt && (req_dt != 6'd0) && pend[req_dt] && !(wb_valid && (wb_addr == req_dt));
    dd_haz = (req_dd != 6'd0) && pend[req_dd] && !(wb_valid && (wb_addr == req_dd));
    // Slot L+1 shifts into slot L at this edge; if occupied the writeback port would collide.
    slot_busy = 1'b0;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (is_op && (i == req_lat + 1)) slot_busy = sr_v[i];
    end
    req_ready = !rst && !flush && !ds_haz && !dt_haz && !dd_haz && !slot_busy;
    accept    = req_valid && req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_v <= '0;
      for (int i = 1; i <= MAX_LAT; i++) sr_addr[i] <= '0;
      pend        <= '0;
      issue_valid <= 1'b0;
      issue_ctrl  <= '0;
      issue_dd    <= '0;
      perf_stall  <= '0;
    end else begin
      if (req_valid && !req_ready && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
      if (flush) begin
        sr_v <= '0;
        for (int i = 1; i <= MAX_LAT; i++) sr_addr[i] <= '0;
        pend        <= '0;
        issue_valid <= 1'b0;
        issue_ctrl  <= '0;
        issue_dd    <= '0;
      end else begin
        for (int i = 1; i < MAX_LAT; i++) begin
          sr_v[i]    <= sr_v[i+1];
          sr_addr[i] <= sr_addr[i+1];
        end
        sr_v[MAX_LAT]    <= 1'b0;
        sr_addr[MAX_LAT] <= '0;
        if (accept && is_op) begin
          for (int i = 1; i <= MAX_LAT; i++) begin
            if (i == req_lat) begin
              sr_v[i]    <= 1'b1;
              sr_addr[i] <= req_dd;
            end
          end
        end
        // Later assignment wins so a same-edge set beats the writeback clear.
        if (wb_valid) pend[wb_addr] <= 1'b0;
        if (accept && is_op && (req_dd != 6'd0)) pend[req_dd] <= 1'b1;
        issue_valid <= accept && is_op;
        issue_ctrl  <= (accept && is_op) ? req_ctrl : 4'd0;
        issue_dd    <= (accept && is_op) ? req_dd : 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: directed scenarios then random traffic, all checked against an
// in-flight-list model that tracks each op's absolute writeback cycle.
module tb_fpu_issue_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ctrl;
  logic [5:0]  req_ds, req_dt, req_dd;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_ctrl;
  logic [5:0]  issue_dd;
  logic        wb_valid;
  logic [5:0]  wb_addr;
  logic        busy;
  logic [15:0] perf_stall;

  always #5 clk = ~clk;

  fpu_issue_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_ds(req_ds), .req_dt(req_dt), .req_dd(req_dd), .flush(flush),
    .issue_valid(issue_valid), .issue_ctrl(issue_ctrl), .issue_dd(issue_dd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .busy(busy), .perf_stall(perf_stall)
  );

  typedef struct {int addr; int wbc;} flight_t;
  flight_t infl[$];
  bit      pend_m [64];
  int      cyc;
  int      perf_m;
  int      exp_iv, exp_ictrl, exp_idd;
  int      n_checks = 0;
  int      n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic int lat_of(input int c);
    if (c == 1 || c == 2) return 2;
    if (c == 3) return 2;
    if (c == 4 || c == 5) return 4;
    return 1;
  endfunction

  function automatic bit haz(input int r, input bit wbv, input int waddr);
    return (r != 0) && pend_m[r] && !(wbv && waddr == r);
  endfunction

  function automatic void model_reset();
    infl.delete();
    foreach (pend_m[i]) pend_m[i] = 0;
    exp_iv = 0; exp_ictrl = 0; exp_idd = 0;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input bit v, input int c, input int ds, input int dt, input int dd,
                      input bit fl, input bit r);
    bit wbv, is_op, udt, uds, conflict, rdy;
    int waddr, l;
    rst = r; req_valid = v; req_ctrl = 4'(c);
    req_ds = 6'(ds); req_dt = 6'(dt); req_dd = 6'(dd); flush = fl;
    @(negedge clk);
    wbv = 0; waddr = 0;
    foreach (infl[i]) if (infl[i].wbc == cyc) begin wbv = 1; waddr = infl[i].addr; end
    is_op = (c >= 1 && c <= 14);
    uds   = (c >= 1 && c <= 13);
    udt   = (c inside {1, 2, 3, 6, 7, 8});
    l     = lat_of(c);
    conflict = 0;
    foreach (infl[i]) if (is_op && infl[i].wbc == cyc + l) conflict = 1;
    rdy = !r && !fl && !(uds && haz(ds, wbv, waddr)) && !(udt && haz(dt, wbv, waddr)) &&
          !haz(dd, wbv, waddr) && !conflict;
    check("req_ready",   32'(req_ready),   32'(rdy));
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    check("issue_ctrl",  32'(issue_ctrl),  32'(exp_ictrl));
    check("issue_dd",    32'(issue_dd),    32'(exp_idd));
    check("wb_valid",    32'(wb_valid),    32'(wbv));
    check("wb_addr",     32'(wb_addr),     32'(waddr));
    check("busy",        32'(busy),        32'(infl.size() != 0));
    check("perf_stall",  32'(perf_stall),  32'(perf_m));
    if (r) begin
      model_reset();
      perf_m = 0;
    end else begin
      if (v && !rdy && perf_m < 65535) perf_m++;
      if (fl) model_reset();
      else begin
        for (int i = infl.size() - 1; i >= 0; i--) if (infl[i].wbc == cyc) infl.delete(i);
        if (wbv) pend_m[waddr] = 0;
        exp_iv = 0; exp_ictrl = 0; exp_idd = 0;
        if (v && rdy && is_op) begin
          infl.push_back('{addr: dd, wbc: cyc + l});
          if (dd != 0) pend_m[dd] = 1;
          exp_iv = 1; exp_ictrl = c; exp_idd = dd;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_ctrl = 0; req_ds = 0; req_dt = 0; req_dd = 0; flush = 0;
    cyc = 0; perf_m = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // fadd dd=3
    step(1, 1, 1, 2, 3, 0, 0);
    idle(3);
    // finv dd=5 followed by fadd dd=6 contending for the writeback slot
    step(1, 4, 0, 0, 5, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 6, 0, 0);
    idle(5);
    // fmul dd=7 then dependent fsqrt bypassing on the wb cycle
    step(1, 3, 1, 1, 7, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5, 7, 0, 8, 0, 0);
    idle(5);
    // fadd dd=0 and back-to-back misc ops
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 6 + i, 1, 2, 10 + i, 0, 0);
    idle(3);
    // flush kills finv dd=9, dependent op accepted afterwards
    step(1, 4, 0, 0, 9, 0, 0);
    step(1, 1, 9, 0, 11, 1, 0);
    step(1, 1, 9, 0, 11, 0, 0);
    idle(5);
    // reset while finv in flight
    step(1, 4, 0, 0, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(6);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 15), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end
    // drive the stall counter into saturation
    for (int i = 0; i < 65540; i++) step(1, 1, 0, 0, 1, 1, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
